// File: rtl/index_directory_pkg.sv
// Shared types and sizing helpers for the index-addressed tag store.
// The read response struct is sized by TAG_WIDTH; index_directory's WIDTH
// parameter must stay equal to it.
package index_directory_pkg;

    localparam int TAG_WIDTH = 8;

    typedef struct packed {
        logic                 hit;
        logic [TAG_WIDTH-1:0] tag;
    } rd_rsp_t;

    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/index_directory_count_ones.sv
// Population count of a bit vector, used for the directory occupancy count.
module count_ones
    import index_directory_pkg::*;
#(
    parameter int  WIDTH       = 16,
    localparam int COUNT_WIDTH = count_width(WIDTH)
) (
    input  logic [WIDTH-1:0]       bits_i,
    output logic [COUNT_WIDTH-1:0] count_o
);

    // Ripple sum of the set bits; small enough that a tree buys nothing.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + COUNT_WIDTH'(bits_i[i]);
        end
    end

endmodule

// File: rtl/index_directory.sv
// Index-addressed tag store for the response side of an ID-tracked interface.
// Issue side writes a tag into a slot; completion side reads a slot by index
// and may release it in the same access. Read data is registered (1 cycle).
// Optional feature: define INDEX_DIRECTORY_BYPASS_EN to forward a same-cycle
// write to a read of the same index (release then wins over the write);
// without it the read returns pre-write contents and the write wins.
module index_directory
    import index_directory_pkg::*;
#(
    parameter int  WIDTH       = TAG_WIDTH,
    parameter int  DEPTH       = 16,
    localparam int INDEX_WIDTH = index_width(DEPTH),
    localparam int COUNT_WIDTH = count_width(DEPTH)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   write_enable,
    input  logic [INDEX_WIDTH-1:0] write_index,
    input  logic [WIDTH-1:0]       write_tag,
    input  logic                   read_enable,
    input  logic [INDEX_WIDTH-1:0] read_index,
    input  logic                   read_release,
    output logic [WIDTH-1:0]       read_tag,
    output logic                   read_hit,
    output logic                   read_ready,
    output logic                   write_collision,
    output logic                   full,
    output logic                   empty,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][WIDTH-1:0] tags_q, tags_d;
    rd_rsp_t                     rsp_q, rsp_d;
    logic                        ready_q;
    logic                        coll_q, coll_d;
    logic                        rel;
    logic                        same_idx;

    assign rel      = read_enable & read_release;
    assign same_idx = (write_index == read_index);

    // Next-state of the valid/tag arrays; ordering of write vs release
    // decides who wins when both hit the same slot.
    always_comb begin
        valid_d = valid_q;
        tags_d  = tags_q;
`ifdef INDEX_DIRECTORY_BYPASS_EN
        if (write_enable) begin
            valid_d[write_index] = 1'b1;
            tags_d[write_index]  = write_tag;
        end
        if (rel) valid_d[read_index] = 1'b0;
`else
        if (rel) valid_d[read_index] = 1'b0;
        if (write_enable) begin
            valid_d[write_index] = 1'b1;
            tags_d[write_index]  = write_tag;
        end
`endif
    end

    // Read lookup, plus forwarding of a same-slot write when bypass is built.
    always_comb begin
        rsp_d.hit = valid_q[read_index];
        rsp_d.tag = valid_q[read_index] ? tags_q[read_index] : '0;
`ifdef INDEX_DIRECTORY_BYPASS_EN
        if (write_enable && same_idx) begin
            rsp_d.hit = 1'b1;
            rsp_d.tag = write_tag;
        end
`endif
    end

    // Overwrite of a live entry that is not simultaneously being released.
    always_comb begin
        coll_d = write_enable & valid_q[write_index] & ~(rel & same_idx);
    end

    // State and output registers; reset drops any in-flight read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            tags_q  <= '0;
            rsp_q   <= '0;
            ready_q <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            tags_q  <= tags_d;
            ready_q <= read_enable;
            coll_q  <= coll_d;
            if (read_enable) rsp_q <= rsp_d;
        end
    end

    count_ones #(.WIDTH(DEPTH)) u_count (
        .bits_i  (valid_q),
        .count_o (count)
    );

    assign read_tag        = rsp_q.tag;
    assign read_hit        = rsp_q.hit;
    assign read_ready      = ready_q;
    assign write_collision = coll_q;
    assign full            = &valid_q;
    assign empty           = ~|valid_q;

endmodule

// File: tb/tb_index_directory.sv
// Scoreboard bench for index_directory (WIDTH=8, DEPTH=16). Read expectations
// are queued at issue and popped when read_ready is seen.
module tb_index_directory;

    logic       clock = 1'b0;
    logic       resetn;
    logic       write_enable, read_enable, read_release;
    logic [3:0] write_index, read_index;
    logic [7:0] write_tag;
    logic [7:0] read_tag;
    logic       read_hit, read_ready, write_collision, full, empty;
    logic [4:0] count;

    index_directory #(.WIDTH(8), .DEPTH(16)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .write_enable    (write_enable),
        .write_index     (write_index),
        .write_tag       (write_tag),
        .read_enable     (read_enable),
        .read_index      (read_index),
        .read_release    (read_release),
        .read_tag        (read_tag),
        .read_hit        (read_hit),
        .read_ready      (read_ready),
        .write_collision (write_collision),
        .full            (full),
        .empty           (empty),
        .count           (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       hit;
        logic [7:0] tag;
    } exp_t;

    exp_t       sb[$];
    logic       m_valid[16];
    logic [7:0] m_tag[16];
    exp_t       last_rsp;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 8'h00;
        end
        last_rsp = '{hit: 1'b0, tag: 8'h00};
    endtask

    // Read response monitor: pop expected result on every read_ready.
    always @(negedge clock) begin
        if (resetn && read_ready) begin
            if (sb.size() == 0) begin
                chk("rd_spurious", 32'(read_ready), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_hit", 32'(read_hit), 32'(e.hit));
                chk("rd_tag", 32'(read_tag), 32'(e.tag));
            end
        end
    end

    // One clock of stimulus, called at a negedge; checks per-cycle flags.
    task automatic step(input logic we, input int wi, input logic [7:0] wt,
                        input logic re, input int ri, input logic rel);
        exp_t e;
        logic exp_coll;
        write_enable = we;  write_index = wi[3:0]; write_tag = wt;
        read_enable  = re;  read_index  = ri[3:0]; read_release = rel;
        exp_coll = we && m_valid[wi] && !(re && rel && wi == ri);
        if (re) begin
            e.hit = m_valid[ri];
            e.tag = m_valid[ri] ? m_tag[ri] : 8'h00;
`ifdef INDEX_DIRECTORY_BYPASS_EN
            if (we && wi == ri) begin
                e.hit = 1'b1;
                e.tag = wt;
            end
`endif
            sb.push_back(e);
            last_rsp = e;
        end
`ifdef INDEX_DIRECTORY_BYPASS_EN
        if (we) begin m_valid[wi] = 1'b1; m_tag[wi] = wt; end
        if (re && rel) m_valid[ri] = 1'b0;
`else
        if (re && rel) m_valid[ri] = 1'b0;
        if (we) begin m_valid[wi] = 1'b1; m_tag[wi] = wt; end
`endif
        @(posedge clock);
        @(negedge clock);
        write_enable = 1'b0; read_enable = 1'b0; read_release = 1'b0;
        chk("collision", 32'(write_collision), 32'(exp_coll));
        chk("count", 32'(count), 32'(m_count()));
        chk("full", 32'(full), 32'(m_count() == 16));
        chk("empty", 32'(empty), 32'(m_count() == 0));
    endtask

    initial begin
        resetn = 1'b0;
        write_enable = 1'b0; write_index = '0; write_tag = '0;
        read_enable = 1'b0; read_index = '0; read_release = 1'b0;
        m_clear();
        repeat (3) @(negedge clock);
        resetn = 1'b1;

        // Reset state
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_hit", 32'(read_hit), 32'd0);
        chk("rst_tag", 32'(read_tag), 32'd0);
        chk("rst_ready", 32'(read_ready), 32'd0);
        chk("rst_coll", 32'(write_collision), 32'd0);

        // Basic write then read, then free the slot again
        step(1, 3, 8'hA5, 0, 0, 0);
        step(0, 0, 8'h00, 1, 3, 0);
        step(0, 0, 8'h00, 1, 3, 1);

        // Fill all slots, then overwrite a live one
        for (int i = 0; i < 16; i++) step(1, i, 8'(8'h10 + i), 0, 0, 0);
        step(1, 5, 8'h77, 0, 0, 0);
        step(0, 0, 8'h00, 1, 5, 0);

        // Idle cycle: read outputs hold
        step(0, 0, 8'h00, 0, 0, 0);
        chk("hold_tag", 32'(read_tag), 32'(last_rsp.tag));
        chk("hold_hit", 32'(read_hit), 32'(last_rsp.hit));
        chk("hold_ready", 32'(read_ready), 32'd0);

        // Drain with read-release, then a miss
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1, i, 1);
        step(0, 0, 8'h00, 1, 0, 0);

        // Same-cycle write and read-release of one slot, then observe it
        step(1, 7, 8'h3C, 1, 7, 1);
        step(0, 0, 8'h00, 1, 7, 0);

        // Mixed traffic on a few slots to hit collisions and same-slot cases
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3), 8'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        // Reset with a read in flight and four live entries
        for (int i = 0; i < 4; i++) step(1, i, 8'(8'hC0 + i), 0, 0, 0);
        read_enable = 1'b1; read_index = 4'd1;
        #2 resetn = 1'b0;
        m_clear();
        @(posedge clock);
        @(negedge clock);
        read_enable = 1'b0;
        chk("rst_mid_ready", 32'(read_ready), 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_empty", 32'(empty), 32'd1);
        chk("rst_mid_hit", 32'(read_hit), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, i, 1);

        step(0, 0, 8'h00, 0, 0, 0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/index_directory.md
# index_directory

Index-addressed tag store for the return path of tagged transactions: the issuing side writes a tag into a chosen slot; the completing side reads a slot by index and optionally releases it in the same access. It is the index→tag counterpart of the tag→index tag directory and sits on the response side of an ID-tracked interface. It provides registered read data, occupancy flags and a population count, and flags overwrites of live entries.

## Interface
- WIDTH, 8: tag width in bits.
- DEPTH, 16: number of entries; INDEX_WIDTH = $clog2(DEPTH), COUNT_WIDTH = $clog2(DEPTH+1).
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- write_enable  in  1  store write_tag at write_index and mark the entry valid.
- write_index  in  INDEX_WIDTH  slot to write.
- write_tag  in  WIDTH  tag to store.
- read_enable  in  1  read the entry at read_index.
- read_index  in  INDEX_WIDTH  slot to read.
- read_release  in  1  qualified by read_enable; invalidate the read entry.
- read_tag  out  WIDTH  registered tag of the last read; 0 on a miss.
- read_hit  out  1  registered; last read addressed a valid entry.
- read_ready  out  1  registered pulse; read_tag and read_hit are updated this cycle.
- write_collision  out  1  registered pulse; the last write overwrote a valid entry.
- full  out  1  all entries valid.
- empty  out  1  no entry valid.
- count  out  COUNT_WIDTH  number of valid entries.

## Operation
- State: valid[DEPTH] and tags[DEPTH][WIDTH]; all registers clear on reset.
- Write: on the clock edge with write_enable=1, valid[write_index] is set and tags[write_index] is loaded with write_tag.
- Write collision: if the target entry was already valid and is not being released in the same cycle, write_collision pulses for one cycle. The entry is still overwritten.
- Read: on the clock edge with read_enable=1, the output registers capture the entry's hit and tag. If the entry is invalid, read_hit=0 and read_tag=0.
- Release: read_enable=1 together with read_release=1 clears valid[read_index] on the same edge. Releasing an invalid entry is harmless; read_hit=0.
- Read with read_enable=0: read_tag and read_hit hold their previous values and read_ready=0.
- Write and release of different indices in the same cycle: both take effect.
- Write and release of the same index in the same cycle: behaviour depends on the configuration below.
- Flags are combinational from the registered valid vector: full = &valid, empty = ~|valid, count = popcount(valid).

## Timing
- Read latency is 1 cycle: request on edge N, data and read_ready valid after edge N.
- A write becomes visible to reads issued on the following cycle.
- full, empty and count reflect writes and releases one cycle after the edge.
- Reset values: read_tag=0, read_hit=0, read_ready=0, write_collision=0, full=0, empty=1, count=0.
- Reset is honoured mid-operation: asserting resetn low clears all state immediately. Any in-flight read produces no read_ready.

## Configuration
- INDEX_DIRECTORY_BYPASS_EN defined: a same-cycle write and read to the same index forwards write_tag to read_tag with read_hit=1.
  - If that read also releases, the release wins and the entry ends invalid. The read consumed the written tag.
  - write_collision does not count the released entry.
- INDEX_DIRECTORY_BYPASS_EN undefined: a same-cycle write and read to the same index returns the pre-write contents.
  - The write wins over a same-cycle release, so the entry ends valid with write_tag.

## Structure
- Shared package index_directory_pkg holds:
  - the index and count width helper functions;
  - the read response struct {hit, tag}.
- Sub-module count_ones (parameter WIDTH=DEPTH) computes the popcount for count.
- The rest is a single flat module: the valid/tag arrays, write/release next-state logic, the bypass mux and the output registers.

## Test plan
All scenarios use WIDTH=8 and DEPTH=16.
- Reset → empty=1, full=0, count=0, read_hit=0, read_tag=0.
- Write tag 0xA5 at index 3, then read index 3 → after 1 cycle: read_ready=1, read_hit=1, read_tag=0xA5, count=1.
- Write all 16 indices with tags 0x10+i, then write 0x77 to index 5 → full=1, count=16, write_collision pulses once, read of index 5 returns 0x77.
- Read-release of indices 0..15 → each read hits with the stored tag; count decrements to 0, empty=1; a re-read of index 0 gives read_hit=0, read_tag=0.
- Write 0x3C and read-release index 7 in the same cycle:
  - bypass build: read_tag=0x3C, hit=1, entry invalid afterwards;
  - non-bypass build: hit=0, entry valid with 0x3C afterwards.
- Drop resetn while a read is in flight with 4 entries valid → no read_ready pulse, count=0, all reads miss after release.
